// File: rtl/decode_hazard_ctrl.sv
// Decode-stage issue controller for the 5-stage RV32I pipeline: per-register
// pending-write scoreboard, RAW/full stall, branch flush, writeback clear.
// Latency: stall/issue/flush combinational; scoreboard updates on the next clock.
// Backpressure: id_stall holds PC and IF/ID; ex_br_taken overrides any stall.
// Build option: `define DECODE_HAZARD_FWD_EN selects load-use-only RAW stalling
// (EX/MEM->EX forwarding present); the scoreboard still drives busy_mask/full/sb_err.
// Ports: clk/reset (sync, active-high); id_* decode request; ex_br_taken;
// wb_regwrite/wb_rd writeback; id_issue/id_stall/if_flush/id_flush control;
// busy_mask, stall_cycles, sb_err status.
module decode_hazard_ctrl #(
    parameter int NREG        = 32,
    parameter int PEND_W      = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   ex_br_taken,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_rd,
    output logic                   id_issue,
    output logic                   id_stall,
    output logic                   if_flush,
    output logic                   id_flush,
    output logic [NREG-1:0]        busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   sb_err
);

    localparam logic [PEND_W-1:0]      CNT_MAX   = '1;
    localparam logic [PEND_W-1:0]      CNT_ONE   = PEND_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [PEND_W-1:0]      cnt_q [NREG];
    logic [PEND_W-1:0]      cnt_d [NREG];
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic                   sb_err_q, sb_err_d;

    logic hazard1, hazard2, full;
    logic inc, dec;

`ifdef DECODE_HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded; everything else reaches EX in time.
    logic       ld_pend_q, ld_pend_d;
    logic [4:0] ld_rd_q, ld_rd_d;

    always_comb begin
        hazard1   = ld_pend_q && id_rs1_used && (id_rs1 == ld_rd_q);
        hazard2   = ld_pend_q && id_rs2_used && (id_rs2 == ld_rd_q);
        ld_pend_d = id_issue && id_memread && (id_rd != 5'd0);
        ld_rd_d   = id_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_pend_q <= 1'b0;
            ld_rd_q   <= 5'd0;
        end else begin
            ld_pend_q <= ld_pend_d;
            ld_rd_q   <= ld_rd_d;
        end
    end
`else
    logic unused_memread;
    assign unused_memread = id_memread;

    // A pending write stalls the reader, except when the last outstanding
    // write is landing in the register file this very cycle (write-through).
    always_comb begin
        hazard1 = id_rs1_used && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0) &&
                  !(wb_regwrite && (wb_rd == id_rs1) && (cnt_q[id_rs1] == CNT_ONE));
        hazard2 = id_rs2_used && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0) &&
                  !(wb_regwrite && (wb_rd == id_rs2) && (cnt_q[id_rs2] == CNT_ONE));
    end
`endif

    always_comb begin
        dec  = wb_regwrite && (wb_rd != 5'd0);
        // A saturated counter may still accept a write if WB frees a slot now.
        full = id_regwrite && (id_rd != 5'd0) && (cnt_q[id_rd] == CNT_MAX) &&
               !(dec && (wb_rd == id_rd));

        if_flush = !reset && ex_br_taken;
        id_flush = !reset && ex_br_taken;
        id_stall = !reset && id_valid && !ex_br_taken && (hazard1 || hazard2 || full);
        id_issue = !reset && id_valid && !ex_br_taken && !id_stall;
        inc      = id_issue && id_regwrite && (id_rd != 5'd0);

        sb_err_d = sb_err_q || (dec && (cnt_q[wb_rd] == '0));

        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc && (id_rd == 5'(r)) && !(dec && (wb_rd == 5'(r)))) begin
                if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && (wb_rd == 5'(r)) && !(inc && (id_rd == 5'(r)))) begin
                if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (id_stall && (stall_cycles_q != STALL_MAX)) stall_cycles_d = stall_cycles_q + 1'b1;

        busy_mask = '0;
        for (int r = 1; r < NREG; r++) busy_mask[r] = (cnt_q[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            stall_cycles_q <= '0;
            sb_err_q       <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            stall_cycles_q <= stall_cycles_d;
            sb_err_q       <= sb_err_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_br_taken, wb_regwrite;
    logic        id_issue, id_stall, if_flush, id_flush, sb_err;
    logic [31:0] busy_mask;
    logic [15:0] stall_cycles;

    int vectors    = 0;
    int miscompares = 0;

    decode_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .id_issue(id_issue), .id_stall(id_stall),
        .if_flush(if_flush), .id_flush(id_flush), .busy_mask(busy_mask),
        .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; ex_br_taken = 0;
        wb_regwrite = 0; wb_rd = 0;
    endtask

    // Drive an ID instruction: rd/regwrite/memread, rs1/rs2 with used flags.
    task automatic drive_id(input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        id_valid = 1; id_rd = rd; id_regwrite = rw; id_memread = mr;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    endtask

    task automatic test_reset();
        reset = 1;
        drive_id(5'd5, 1, 1, 5'd5, 1, 5'd6, 1);
        ex_br_taken = 1; wb_regwrite = 1; wb_rd = 5'd3;
        #1;
        vectors++; if (id_issue !== 1'b0) begin miscompares++; $display("FAIL rst_issue got=%0b exp=0", id_issue); end
        vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%0b exp=0", id_stall); end
        vectors++; if (if_flush !== 1'b0) begin miscompares++; $display("FAIL rst_if_flush got=%0b exp=0", if_flush); end
        vectors++; if (id_flush !== 1'b0) begin miscompares++; $display("FAIL rst_id_flush got=%0b exp=0", id_flush); end
        step();
        vectors++; if (busy_mask !== 32'h0) begin miscompares++; $display("FAIL rst_busy got=%h exp=0", busy_mask); end
        vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_stall_cycles got=%0d exp=0", stall_cycles); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL rst_sb_err got=%0b exp=0", sb_err); end
        reset = 0;
        idle();
        step();
    endtask

    task automatic test_raw();
        // add x5,x1,x2
        drive_id(5'd5, 1, 0, 5'd1, 1, 5'd2, 1); #1;
        vectors++; if (id_issue !== 1'b1) begin miscompares++; $display("FAIL raw_first_issue got=%0b exp=1", id_issue); end
        step();
        vectors++; if (busy_mask !== 32'h0000_0020) begin miscompares++; $display("FAIL raw_busy5 got=%h exp=00000020", busy_mask); end
        // sub x6,x5,x1 waits two cycles, then WB x5 writes through
        drive_id(5'd6, 1, 0, 5'd5, 1, 5'd1, 1);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (id_stall !== 1'b1 || id_issue !== 1'b0) begin miscompares++; $display("FAIL raw_stall cyc%0d got stall=%0b issue=%0b exp stall=1 issue=0", i, id_stall, id_issue); end
            step();
        end
        wb_regwrite = 1; wb_rd = 5'd5; #1;
        vectors++; if (id_stall !== 1'b0 || id_issue !== 1'b1) begin miscompares++; $display("FAIL raw_writethrough got stall=%0b issue=%0b exp stall=0 issue=1", id_stall, id_issue); end
        step();
        vectors++; if (busy_mask !== 32'h0000_0040) begin miscompares++; $display("FAIL raw_after_wb got=%h exp=00000040", busy_mask); end
        vectors++; if (stall_cycles !== 16'd2) begin miscompares++; $display("FAIL raw_stall_cycles got=%0d exp=2", stall_cycles); end
        idle(); wb_regwrite = 1; wb_rd = 5'd6;
        step();
        idle();
        vectors++; if (busy_mask !== 32'h0) begin miscompares++; $display("FAIL raw_drain got=%h exp=0", busy_mask); end
    endtask

    task automatic test_stall_count();
        drive_id(5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive_id(5'd0, 0, 0, 5'd10, 1, 5'd0, 0);
        repeat (8) step();
        vectors++; if (stall_cycles !== 16'd10) begin miscompares++; $display("FAIL stall_cycles got=%0d exp=10", stall_cycles); end
        wb_regwrite = 1; wb_rd = 5'd10; #1;
        vectors++; if (id_issue !== 1'b1) begin miscompares++; $display("FAIL stall_release got=%0b exp=1", id_issue); end
        step();
        idle();
    endtask

    task automatic test_full();
        // addi x7,x0,1 three times fills a 2-bit counter
        drive_id(5'd7, 1, 0, 5'd0, 1, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (id_issue !== 1'b1) begin miscompares++; $display("FAIL full_issue%0d got=%0b exp=1", i, id_issue); end
            step();
        end
        #1;
        vectors++; if (id_stall !== 1'b1 || id_issue !== 1'b0) begin miscompares++; $display("FAIL full_stall got stall=%0b issue=%0b exp stall=1 issue=0", id_stall, id_issue); end
        step();
        wb_regwrite = 1; wb_rd = 5'd7; #1;
        vectors++; if (id_stall !== 1'b0 || id_issue !== 1'b1) begin miscompares++; $display("FAIL full_release got stall=%0b issue=%0b exp stall=0 issue=1", id_stall, id_issue); end
        step();
        id_valid = 0; id_regwrite = 0;
        repeat (3) step();
        idle();
        vectors++; if (busy_mask !== 32'h0) begin miscompares++; $display("FAIL full_drain got=%h exp=0", busy_mask); end
    endtask

    task automatic test_branch();
        drive_id(5'd8, 1, 0, 5'd0, 0, 5'd0, 0);
        step();
        // reader of x8 in ID while EX resolves a taken branch
        drive_id(5'd9, 1, 0, 5'd8, 1, 5'd0, 0);
        ex_br_taken = 1; #1;
        vectors++; if ({if_flush, id_flush, id_stall, id_issue} !== 4'b1100) begin miscompares++; $display("FAIL br_ctrl got flush_if/id/stall/issue=%b exp=1100", {if_flush, id_flush, id_stall, id_issue}); end
        step();
        idle();
        vectors++; if (busy_mask !== 32'h0000_0100) begin miscompares++; $display("FAIL br_busy got=%h exp=00000100", busy_mask); end
        wb_regwrite = 1; wb_rd = 5'd8;
        step();
        idle();
    endtask

    task automatic test_sb_err();
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL sberr_pre got=%0b exp=0", sb_err); end
        wb_regwrite = 1; wb_rd = 5'd9;
        step();
        idle();
        vectors++; if (sb_err !== 1'b1 || busy_mask !== 32'h0) begin miscompares++; $display("FAIL sberr_set got err=%0b busy=%h exp err=1 busy=0", sb_err, busy_mask); end
        repeat (3) step();
        vectors++; if (sb_err !== 1'b1) begin miscompares++; $display("FAIL sberr_sticky got=%0b exp=1", sb_err); end
        reset = 1;
        step();
        reset = 0;
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL sberr_reset got=%0b exp=0", sb_err); end
        step();
    endtask

    task automatic test_x0();
        drive_id(5'd0, 1, 0, 5'd0, 1, 5'd0, 1); #1;
        vectors++; if (id_issue !== 1'b1) begin miscompares++; $display("FAIL x0_issue got=%0b exp=1", id_issue); end
        step();
        #1;
        vectors++; if (busy_mask !== 32'h0 || id_stall !== 1'b0) begin miscompares++; $display("FAIL x0_busy got busy=%h stall=%0b exp busy=0 stall=0", busy_mask, id_stall); end
        idle();
        step();
    endtask

`ifdef DECODE_HAZARD_FWD_EN
    task automatic test_fwd_load_use();
        // lw x3,0(x1); add x4,x3,x3 -> one stall
        drive_id(5'd3, 1, 1, 5'd1, 1, 5'd0, 0); #1;
        vectors++; if (id_issue !== 1'b1) begin miscompares++; $display("FAIL fwd_lw_issue got=%0b exp=1", id_issue); end
        step();
        drive_id(5'd4, 1, 0, 5'd3, 1, 5'd3, 1); #1;
        vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL fwd_lu_stall got=%0b exp=1", id_stall); end
        step();
        #1;
        vectors++; if (id_stall !== 1'b0 || id_issue !== 1'b1) begin miscompares++; $display("FAIL fwd_lu_release got stall=%0b issue=%0b exp stall=0 issue=1", id_stall, id_issue); end
        step();
        // add x3; add x4,x3,x3 -> forwarded, no stall despite pending writes
        drive_id(5'd3, 1, 0, 5'd1, 1, 5'd0, 0);
        step();
        drive_id(5'd4, 1, 0, 5'd3, 1, 5'd3, 1); #1;
        vectors++; if (id_stall !== 1'b0 || id_issue !== 1'b1) begin miscompares++; $display("FAIL fwd_alu_nostall got stall=%0b issue=%0b exp stall=0 issue=1", id_stall, id_issue); end
        step();
        idle();
        vectors++; if (busy_mask !== 32'h0000_0018) begin miscompares++; $display("FAIL fwd_busy got=%h exp=00000018", busy_mask); end
        reset = 1;
        step();
        reset = 0;
        step();
    endtask
`endif

    initial begin
        idle();
        reset = 1;
        test_reset();
`ifdef DECODE_HAZARD_FWD_EN
        test_fwd_load_use();
`else
        test_raw();
        test_stall_count();
`endif
        test_full();
        test_branch();
        test_x0();
        test_sb_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
